// File: rtl/cw_pkg.sv
// Shared types and width helpers for the constant-weight codeword encoder.
// Default M/T match the n=1024, t=38 production configuration.
package cw_pkg;

   localparam int DEF_M = 10;
   localparam int DEF_T = 38;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_BEST_D    = 3'd1,
      ST_READ_FLAG = 3'd2,
      ST_READ_IDX  = 3'd3,
      ST_EMIT      = 3'd4,
      ST_FILL      = 3'd5,
      ST_DONE      = 3'd6
   } cw_state_e;

   function automatic int n_width(input int m);
      return m + 32'sd1;
   endfunction

   function automatic int t_width(input int t);
      return $clog2(t + 32'sd1);
   endfunction

   function automatic int u_width(input int m);
      return $clog2(m + 32'sd1);
   endfunction

   function automatic int bits_width(input int m, input int t);
      return $clog2(t * m + 32'sd1);
   endfunction

endpackage

// File: rtl/cw_encoder_param_if.sv
// Message-bit and codeword streams plus status of one encoder instance.
interface cw_encoder_param_if import cw_pkg::*; #(
   parameter int M = DEF_M,
   parameter int T = DEF_T
);
   logic                          start;
   logic                          msg_bit;
   logic                          msg_valid;
   logic                          msg_ready;
   logic [M-1:0]                  cw_word;
   logic                          cw_valid;
   logic                          cw_ready;
   logic                          busy;
   logic                          done;
   logic [bits_width(M, T)-1:0]   bits_used;

   modport master (
      output start, msg_bit, msg_valid, cw_ready,
      input  msg_ready, cw_word, cw_valid, busy, done, bits_used
   );

   modport slave (
      input  start, msg_bit, msg_valid, cw_ready,
      output msg_ready, cw_word, cw_valid, busy, done, bits_used
   );
endinterface

// File: rtl/cw_best_d.sv
// Picks u = largest integer with t*2^u <= n - ((t-1)>>1), 0 if none.
// All shifts are compared in parallel; result is registered one cycle after start.
module cw_best_d import cw_pkg::*; #(
   parameter int M = DEF_M,
   parameter int T = DEF_T
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [n_width(M)-1:0]  n,
   input  logic [t_width(T)-1:0]  t,
   output logic [u_width(M)-1:0]  u,
   output logic                   u_valid
);
   localparam int NW = n_width(M);
   localparam int TW = t_width(T);
   localparam int UW = u_width(M);
   localparam int WW = NW + TW;
   localparam logic [TW-1:0] T1 = {{(TW-1){1'b0}}, 1'b1};

   logic [WW-1:0] half_s;
   logic [WW-1:0] rhs_s;
   logic [M:0]    fit_s;
   logic [UW-1:0] u_s;
   logic [UW-1:0] u_r;
   logic          u_valid_r;

   // Parallel shift-compare followed by a highest-set priority encoder
   always_comb begin
      half_s = WW'(t - T1) >> 1;
      if (WW'(n) >= half_s) begin
         rhs_s = WW'(n) - half_s;
      end else begin
         rhs_s = {WW{1'b0}};
      end
      for (int k = 0; k <= M; k++) begin
         fit_s[k] = ((WW'(t) << k) <= rhs_s);
      end
      u_s = {UW{1'b0}};
      for (int k = 0; k <= M; k++) begin
         u_s = fit_s[k] ? UW'(k) : u_s;
      end
   end

   // Result register; u holds its value until the next launch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         u_r       <= {UW{1'b0}};
         u_valid_r <= 1'b0;
      end else begin
         u_valid_r <= start;
         if (start) begin
            u_r <= u_s;
         end
      end
   end

   assign u       = u_r;
   assign u_valid = u_valid_r;
endmodule

// File: rtl/cw_encoder_param.sv
// Serial constant-weight encoder: consumes message bits and emits t gap-coded
// one positions of an n = 2^M bit codeword.
module cw_encoder_param import cw_pkg::*; #(
   parameter int M = DEF_M,
   parameter int T = DEF_T
) (
   input  logic               clk,
   input  logic               rst,
   cw_encoder_param_if.slave  bus
);
   localparam int NW = n_width(M);
   localparam int TW = t_width(T);
   localparam int UW = u_width(M);
   localparam int BW = bits_width(M, T);
   localparam int CW = NW + TW;
   localparam logic [NW-1:0] N_INIT = {1'b1, {M{1'b0}}};
   localparam logic [NW-1:0] N1     = {{(NW-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0] T_INIT = TW'(T);
   localparam logic [TW-1:0] T1     = {{(TW-1){1'b0}}, 1'b1};
   localparam logic [UW-1:0] U1     = {{(UW-1){1'b0}}, 1'b1};
   localparam logic [BW-1:0] B1     = {{(BW-1){1'b0}}, 1'b1};
   localparam logic [BW-1:0] BU_MAX = {BW{1'b1}};

   cw_state_e     state_r, state_s;
   logic          pend_r, pend_s;
   logic [NW-1:0] n_r, n_s;
   logic [TW-1:0] t_r, t_s;
   logic [M-1:0]  delta_r, delta_s;
   logic [M-1:0]  idx_r, idx_s;
   logic [UW-1:0] cnt_r, cnt_s;
   logic [BW-1:0] bits_used_r, bits_used_s;
   logic          msg_ready_r, msg_ready_s;
   logic          cw_valid_r, cw_valid_s;
   logic [M-1:0]  cw_word_r, cw_word_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;

   logic          launch_s;
   logic [UW-1:0] best_u_s;
   logic          best_valid_s;
   logic [NW-1:0] d_s;
   logic          bit_xfer_s;
   logic          word_xfer_s;
   logic          n_le_t_s;

   cw_best_d #(.M(M), .T(T)) u_best_d (
      .clk     (clk),
      .rst     (rst),
      .start   (launch_s),
      .n       (n_r),
      .t       (t_r),
      .u       (best_u_s),
      .u_valid (best_valid_s)
   );

   // Next-state, datapath updates and next values of the registered outputs
   always_comb begin
      state_s     = state_r;
      pend_s      = pend_r;
      n_s         = n_r;
      t_s         = t_r;
      delta_s     = delta_r;
      idx_s       = idx_r;
      cnt_s       = cnt_r;
      bits_used_s = bits_used_r;
      launch_s    = 1'b0;

      bit_xfer_s  = msg_ready_r & bus.msg_valid;
      word_xfer_s = cw_valid_r & bus.cw_ready;
      d_s         = N1 << best_u_s;
      n_le_t_s    = (CW'(n_r) <= CW'(t_r));

      if (bit_xfer_s && (bits_used_r != BU_MAX)) begin
         bits_used_s = bits_used_r + B1;
      end else begin
         bits_used_s = bits_used_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               n_s         = N_INIT;
               t_s         = T_INIT;
               delta_s     = {M{1'b0}};
               bits_used_s = {BW{1'b0}};
               pend_s      = 1'b0;
               state_s     = ST_BEST_D;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BEST_D: begin
            // pend_r marks the second cycle, spent waiting for the registered u
            if (pend_r) begin
               if (best_valid_s) begin
                  pend_s  = 1'b0;
                  state_s = ST_READ_FLAG;
               end else begin
                  state_s = ST_BEST_D;
               end
            end else if (t_r == {TW{1'b0}}) begin
               state_s = ST_DONE;
            end else if (n_le_t_s) begin
               state_s = ST_FILL;
            end else begin
               launch_s = 1'b1;
               pend_s   = 1'b1;
            end
         end
         ST_READ_FLAG: begin
            if (bit_xfer_s) begin
               if (bus.msg_bit) begin
                  delta_s = delta_r + d_s[M-1:0];
                  n_s     = n_r - d_s;
                  state_s = ST_BEST_D;
               end else begin
                  idx_s = {M{1'b0}};
                  cnt_s = {UW{1'b0}};
                  if (best_u_s == {UW{1'b0}}) begin
                     state_s = ST_EMIT;
                  end else begin
                     state_s = ST_READ_IDX;
                  end
               end
            end else begin
               state_s = ST_READ_FLAG;
            end
         end
         ST_READ_IDX: begin
            if (bit_xfer_s) begin
               idx_s = (idx_r << 1) | {{(M-1){1'b0}}, bus.msg_bit};
               cnt_s = cnt_r + U1;
               if (cnt_r == (best_u_s - U1)) begin
                  state_s = ST_EMIT;
               end else begin
                  state_s = ST_READ_IDX;
               end
            end else begin
               state_s = ST_READ_IDX;
            end
         end
         ST_EMIT: begin
            if (word_xfer_s) begin
               n_s     = n_r - ({1'b0, idx_r} + N1);
               t_s     = t_r - T1;
               delta_s = {M{1'b0}};
               state_s = ST_BEST_D;
            end else begin
               state_s = ST_EMIT;
            end
         end
         ST_FILL: begin
            // first fill word carries the pending delta, the rest are zero gaps
            if (word_xfer_s) begin
               t_s     = t_r - T1;
               delta_s = {M{1'b0}};
               if (t_r == T1) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_FILL;
               end
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      msg_ready_s = (state_s == ST_READ_FLAG) || (state_s == ST_READ_IDX);
      cw_valid_s  = (state_s == ST_EMIT) || (state_s == ST_FILL);
      busy_s      = (state_s != ST_IDLE);
      done_s      = (state_s == ST_DONE);
      if (state_s == ST_EMIT) begin
         cw_word_s = delta_s + idx_s;
      end else if (state_s == ST_FILL) begin
         cw_word_s = delta_s;
      end else begin
         cw_word_s = {M{1'b0}};
      end
   end

   // State, working registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         pend_r      <= 1'b0;
         n_r         <= N_INIT;
         t_r         <= T_INIT;
         delta_r     <= {M{1'b0}};
         idx_r       <= {M{1'b0}};
         cnt_r       <= {UW{1'b0}};
         bits_used_r <= {BW{1'b0}};
         msg_ready_r <= 1'b0;
         cw_valid_r  <= 1'b0;
         cw_word_r   <= {M{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         pend_r      <= pend_s;
         n_r         <= n_s;
         t_r         <= t_s;
         delta_r     <= delta_s;
         idx_r       <= idx_s;
         cnt_r       <= cnt_s;
         bits_used_r <= bits_used_s;
         msg_ready_r <= msg_ready_s;
         cw_valid_r  <= cw_valid_s;
         cw_word_r   <= cw_word_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   assign bus.msg_ready = msg_ready_r;
   assign bus.cw_valid  = cw_valid_r;
   assign bus.cw_word   = cw_word_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.bits_used = bits_used_r;
endmodule

// File: tb/tb_cw_encoder_param.sv
// Bench for cw_encoder_param: a small M=4,T=2 instance for hand-checked vectors
// and a full-size M=10,T=38 instance for random streams against a model.
module tb_cw_encoder_param;
   import cw_pkg::*;

   localparam int MS = 4;
   localparam int TS = 2;
   localparam int ML = 10;
   localparam int TL = 38;

   typedef bit bitq_t[$];
   typedef struct {
      int        len;
      bit [15:0] bits;
      int        w0;
      int        w1;
      int        used;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cw_encoder_param_if #(.M(MS), .T(TS)) bus_s ();
   cw_encoder_param_if #(.M(ML), .T(TL)) bus_l ();

   cw_encoder_param #(.M(MS), .T(TS)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));
   cw_encoder_param #(.M(ML), .T(TL)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

   logic sel_big, start_v, bit_v, valid_v, ready_v;
   assign bus_s.start     = start_v & ~sel_big;
   assign bus_s.msg_bit   = bit_v;
   assign bus_s.msg_valid = valid_v & ~sel_big;
   assign bus_s.cw_ready  = ready_v & ~sel_big;
   assign bus_l.start     = start_v & sel_big;
   assign bus_l.msg_bit   = bit_v;
   assign bus_l.msg_valid = valid_v & sel_big;
   assign bus_l.cw_ready  = ready_v & sel_big;

   logic o_ready, o_valid, o_busy, o_done;
   int   o_word, o_used;
   always_comb begin
      o_ready = sel_big ? bus_l.msg_ready : bus_s.msg_ready;
      o_valid = sel_big ? bus_l.cw_valid  : bus_s.cw_valid;
      o_busy  = sel_big ? bus_l.busy      : bus_s.busy;
      o_done  = sel_big ? bus_l.done      : bus_s.done;
      o_word  = sel_big ? int'(bus_l.cw_word)   : int'(bus_s.cw_word);
      o_used  = sel_big ? int'(bus_l.bits_used) : int'(bus_s.bits_used);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Encoding rules applied directly with integer arithmetic
   function automatic void ref_encode(input int m, input int tt, input bitq_t s,
                                      output int words[$], output int used);
      int n, t, delta, p, u, idx;
      n = 1 << m; t = tt; delta = 0; p = 0;
      words = {};
      while (t > 0) begin
         if (n <= t) begin
            words.push_back(delta % (1 << m));
            for (int k = 1; k < t; k++) words.push_back(0);
            t = 0;
         end else begin
            u = 0;
            for (int k = 0; k <= m; k++)
               if (t * (1 << k) <= n - (t - 1) / 2) u = k;
            if (s[p] == 1'b1) begin
               p++;
               delta += (1 << u);
               n -= (1 << u);
            end else begin
               p++;
               idx = 0;
               for (int k = 0; k < u; k++) begin
                  idx = idx * 2 + int'(s[p]);
                  p++;
               end
               words.push_back((delta + idx) % (1 << m));
               n -= idx + 1;
               t--;
               delta = 0;
            end
         end
      end
      used = p;
   endfunction

   function automatic bitq_t mkq(input vec_t v);
      bitq_t q;
      for (int i = 0; i < v.len; i++) q.push_back(v.bits[i]);
      return q;
   endfunction

   // Drive one codeword's worth of handshakes and collect transferred words
   task automatic run_cw(input bitq_t bits, input bit gaps, input int stall,
                         input int stall_word, input bit hold_start,
                         output int words[$], output int used, output int dones);
      int p, cyc, stall_left;
      bit fin;
      p = 0; cyc = 0; fin = 1'b0; stall_left = stall;
      words = {}; dones = 0;
      start_v = 1'b1; valid_v = 1'b0; ready_v = 1'b0;
      @(posedge clk); #1;
      chk("start_busy", int'(o_busy), 1);
      if (!hold_start) start_v = 1'b0;
      while (!fin && cyc < 5000) begin
         if (o_done) dones++;
         if (dones > 0 && !o_busy) begin
            start_v = 1'b0;
            fin = 1'b1;
         end else begin
            valid_v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bit_v   = (p < bits.size()) ? bits[p] : 1'b0;
            if (o_valid && stall_left > 0) begin
               ready_v = 1'b0;
               chk("stall_word", o_word, stall_word);
               chk("stall_msg_ready", int'(o_ready), 0);
               stall_left--;
            end else begin
               ready_v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (o_ready && valid_v) p++;
            if (o_valid && ready_v) words.push_back(o_word);
            @(posedge clk); #1;
            cyc++;
         end
      end
      valid_v = 1'b0; ready_v = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: still busy=%0d after %0d cycles, expected completion", o_busy, cyc);
      end
      used = o_used;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_msg_ready"}, int'(o_ready), 0);
      chk({tag, "_cw_valid"},  int'(o_valid), 0);
      chk({tag, "_cw_word"},   o_word, 0);
      chk({tag, "_busy"},      int'(o_busy), 0);
      chk({tag, "_done"},      int'(o_done), 0);
      chk({tag, "_bits_used"}, o_used, 0);
   endtask

   task automatic cmp_words(input string tag, input int act[$], input int exp[$]);
      chk({tag, "_count"}, act.size(), exp.size());
      for (int k = 0; k < exp.size(); k++)
         chk({tag, "_word"}, (k < act.size()) ? act[k] : -1, exp[k]);
   endtask

   initial begin
      vec_t  vt[4];
      bitq_t q;
      int    words[$];
      int    exp_w[$];
      int    used, exp_used, dones, p, sum, pos, dup;
      bit    seen[1024];

      vt[0] = '{7, 16'h005A, 5, 9, 7};
      vt[1] = '{3, 16'h0007, 14, 0, 3};
      vt[2] = '{8, 16'h0000, 0, 0, 8};
      vt[3] = '{5, 16'h001E, 7, 8, 5};

      sel_big = 1'b0; start_v = 1'b0; bit_v = 1'b0; valid_v = 1'b0; ready_v = 1'b0;
      rst = 1'b1;
      #12;
      chk_reset_outputs("rst_small");
      sel_big = 1'b1; #1;
      chk_reset_outputs("rst_big");
      sel_big = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_cw(mkq(vt[i]), 1'b0, 0, 0, 1'b0, words, used, dones);
         chk("tbl_count", words.size(), 2);
         chk("tbl_w0", (words.size() > 0) ? words[0] : -1, vt[i].w0);
         chk("tbl_w1", (words.size() > 1) ? words[1] : -1, vt[i].w1);
         chk("tbl_bits_used", used, vt[i].used);
         chk("tbl_done_once", dones, 1);
      end

      run_cw(mkq(vt[0]), 1'b0, 5, 5, 1'b0, words, used, dones);
      chk("stall_w0", (words.size() > 0) ? words[0] : -1, 5);
      chk("stall_w1", (words.size() > 1) ? words[1] : -1, 9);
      chk("stall_bits_used", used, 7);

      run_cw(mkq(vt[0]), 1'b0, 0, 0, 1'b1, words, used, dones);
      chk("hold_count", words.size(), 2);
      chk("hold_done_once", dones, 1);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("hold_idle_busy", int'(o_busy), 0);
      end

      q = mkq(vt[0]);
      p = 0;
      start_v = 1'b1;
      @(posedge clk); #1;
      start_v = 1'b0; valid_v = 1'b1;
      for (int c = 0; c < 5; c++) begin
         bit_v = q[p];
         if (o_ready) p++;
         @(posedge clk); #1;
      end
      chk("mid_idx_busy", int'(o_busy), 1);
      chk("mid_idx_ready", int'(o_ready), 1);
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("rst_mid");
      valid_v = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_cw(q, 1'b0, 0, 0, 1'b0, words, used, dones);
      chk("rerun_w0", (words.size() > 0) ? words[0] : -1, 5);
      chk("rerun_w1", (words.size() > 1) ? words[1] : -1, 9);
      chk("rerun_bits_used", used, 7);

      for (int r = 0; r < 8; r++) begin
         q = {};
         for (int i = 0; i < 40; i++) q.push_back(1'($urandom_range(0, 1)));
         ref_encode(MS, TS, q, exp_w, exp_used);
         run_cw(q, 1'b1, 0, 0, 1'b0, words, used, dones);
         cmp_words("rnd_small", words, exp_w);
         chk("rnd_small_bits_used", used, exp_used);
      end

      sel_big = 1'b1;
      for (int r = 0; r < 4; r++) begin
         q = {};
         for (int i = 0; i < 4096; i++) q.push_back(1'($urandom_range(0, 1)));
         ref_encode(ML, TL, q, exp_w, exp_used);
         run_cw(q, 1'b1, 0, 0, 1'b0, words, used, dones);
         cmp_words("rnd_big", words, exp_w);
         chk("rnd_big_bits_used", used, exp_used);
         chk("rnd_big_done_once", dones, 1);
         sum = 0; pos = -1; dup = 0;
         for (int k = 0; k < 1024; k++) seen[k] = 1'b0;
         foreach (words[k]) begin
            sum += words[k] + 1;
            pos += words[k] + 1;
            if (pos > 1023 || seen[pos]) dup++;
            else seen[pos] = 1'b1;
         end
         chk("rnd_big_sum_le_n", int'(sum <= 1024), 1);
         chk("rnd_big_positions_distinct", dup, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
